// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Also holds the target alignment helper.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam int unsigned STEP_DEFAULT     = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [63:0] ALIGN_MASK       = ~64'h0000_0000_0000_0003;

  // Redirect targets are always word aligned before they reach the PC.
  function automatic logic [63:0] align_addr(input logic [63:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Three-source next-PC select built as two cascaded 2:1 stages:
// sequential/branch first, then that result against the jump target.
module pc_next_mux #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] seq_pc_i,
  input  logic [WIDTH-1:0] branch_tgt_i,
  input  logic [WIDTH-1:0] jump_tgt_i,
  input  logic             branch_sel_i,
  input  logic             jump_sel_i,
  output logic [WIDTH-1:0] next_pc_o
);

  logic [WIDTH-1:0] stage1_s;

  assign stage1_s  = branch_sel_i ? branch_tgt_i : seq_pc_i;
  assign next_pc_o = jump_sel_i ? jump_tgt_i : stage1_s;

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC holder with IDLE/RUN/HALT run control, valid/ready
// hand-off of the PC, jump/branch redirects and a saturating issue counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned     STEP     = STEP_DEFAULT,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_tgt,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_tgt,
  input  logic             pc_ready,
  output logic             pc_valid,
  output logic [WIDTH-1:0] pc,
  output logic [CNT_W-1:0] issue_cnt,
  output logic             running
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  logic             xfer_s;
  logic             redir_s;
  logic             load_s;
  logic [WIDTH-1:0] seq_pc_s;
  logic [WIDTH-1:0] branch_al_s;
  logic [WIDTH-1:0] jump_al_s;
  logic [WIDTH-1:0] mux_pc_s;

  assign seq_pc_s    = pc_q + WIDTH'(STEP);
  assign branch_al_s = WIDTH'(align_addr(64'(branch_tgt)));
  assign jump_al_s   = WIDTH'(align_addr(64'(jump_tgt)));

  pc_next_mux #(.WIDTH(WIDTH)) u_next_mux (
    .seq_pc_i     (seq_pc_s),
    .branch_tgt_i (branch_al_s),
    .jump_tgt_i   (jump_al_s),
    .branch_sel_i (branch_en),
    .jump_sel_i   (jump_en),
    .next_pc_o    (mux_pc_s)
  );

  // Run-state transitions; halt always wins over start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (halt)       state_d = ST_IDLE;
        else if (start) state_d = ST_RUN;
        else            state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (halt) state_d = ST_HALT;
        else      state_d = ST_RUN;
      end
      ST_HALT: begin
        if (start && !halt) state_d = ST_RUN;
        else                state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A redirect without a transfer flushes the stalled PC; in HALT only redirects move it.
  always_comb begin
    xfer_s  = 1'b0;
    redir_s = 1'b0;
    load_s  = 1'b0;
    if (state_q == ST_RUN) begin
      xfer_s  = pc_ready;
      redir_s = jump_en | branch_en;
      load_s  = xfer_s | redir_s;
    end else if (state_q == ST_HALT) begin
      redir_s = jump_en | branch_en;
      load_s  = redir_s;
    end else begin
      load_s  = 1'b0;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    valid_d = (state_d == ST_RUN);
    if (load_s) begin
      pc_d = mux_pc_s;
    end else begin
      pc_d = pc_q;
    end
    if (xfer_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= {CNT_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = valid_q;
  assign running   = valid_q;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run, all compared against a behavioural run/halt/pc/count model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, branch_en, jump_en, pc_ready;
  logic [31:0] branch_tgt, jump_tgt;
  logic        pc_valid, running;
  logic [31:0] pc;
  logic [3:0]  issue_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_run, m_halted;
  logic [31:0] m_pc;
  int          m_cnt;

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0), .STEP(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .branch_en(branch_en), .branch_tgt(branch_tgt),
    .jump_en(jump_en), .jump_tgt(jump_tgt), .pc_ready(pc_ready),
    .pc_valid(pc_valid), .pc(pc), .issue_cnt(issue_cnt), .running(running)
  );

  task automatic model_reset();
    m_run = 1'b0; m_halted = 1'b0; m_pc = 32'h0; m_cnt = 0;
  endtask

  task automatic clear_inputs();
    start = 1'b0; halt = 1'b0; branch_en = 1'b0; jump_en = 1'b0;
    pc_ready = 1'b0; branch_tgt = 32'h0; jump_tgt = 32'h0;
  endtask

  // Advance one clock: model computes its next state from the inputs seen at the edge.
  task automatic tick();
    bit          n_run, n_halted, redir;
    logic [31:0] n_pc, tgt;
    int          n_cnt;
    n_run = m_run; n_halted = m_halted; n_pc = m_pc; n_cnt = m_cnt;
    redir = jump_en || branch_en;
    tgt   = (jump_en ? jump_tgt : branch_tgt) & 32'hFFFF_FFFC;
    if (m_run) begin
      if (redir)         n_pc = tgt;
      else if (pc_ready) n_pc = m_pc + 32'd4;
      if (pc_ready)      n_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
      if (halt) begin n_run = 1'b0; n_halted = 1'b1; end
    end else if (m_halted) begin
      if (redir) n_pc = tgt;
      if (start && !halt) begin n_run = 1'b1; n_halted = 1'b0; end
    end else begin
      if (start && !halt) n_run = 1'b1;
    end
    @(posedge clk);
    m_run = n_run; m_halted = n_halted; m_pc = n_pc; m_cnt = n_cnt;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #12;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", pc_valid); end
    checks++; if (issue_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", issue_cnt); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    start = 1'b1; pc_ready = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pc_valid !== 1'b1 || running !== 1'b1) begin
      errors++; $display("FAIL seq_start_valid got %b/%b exp 1/1", pc_valid, running);
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, 32'(i * 4)); end
      tick();
    end
    checks++; if (issue_cnt !== 4'd4) begin errors++; $display("FAIL seq_cnt got %0d exp 4", issue_cnt); end
  endtask

  task automatic test_stall();
    pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h10 || pc_valid !== 1'b1 || issue_cnt !== 4'd4) begin
        errors++; $display("FAIL stall[%0d] got pc=%h v=%b cnt=%0d exp pc=10 v=1 cnt=4", i, pc, pc_valid, issue_cnt);
      end
    end
    pc_ready = 1'b1;
    tick();
    checks++; if (pc !== 32'h14 || issue_cnt !== 4'd5) begin
      errors++; $display("FAIL stall_release got pc=%h cnt=%0d exp pc=14 cnt=5", pc, issue_cnt);
    end
  endtask

  task automatic test_redirect();
    jump_en = 1'b1; jump_tgt = 32'h200; branch_en = 1'b1; branch_tgt = 32'h100; pc_ready = 1'b1;
    tick();
    checks++; if (pc !== 32'h200 || issue_cnt !== 4'd6) begin
      errors++; $display("FAIL jump_priority got pc=%h cnt=%0d exp pc=200 cnt=6", pc, issue_cnt);
    end
    jump_en = 1'b0; branch_tgt = 32'h103; pc_ready = 1'b0;
    tick();
    branch_en = 1'b0;
    checks++; if (pc !== 32'h100 || issue_cnt !== 4'd6 || pc_valid !== 1'b1) begin
      errors++; $display("FAIL branch_align_flush got pc=%h cnt=%0d v=%b exp pc=100 cnt=6 v=1", pc, issue_cnt, pc_valid);
    end
  endtask

  task automatic test_wrap_saturate();
    jump_en = 1'b1; jump_tgt = 32'hFFFF_FFFE; pc_ready = 1'b0;
    tick();
    jump_en = 1'b0;
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h exp fffffffc", pc); end
    pc_ready = 1'b1;
    tick();
    checks++; if (pc !== 32'h0 || issue_cnt !== 4'd7) begin
      errors++; $display("FAIL wrap got pc=%h cnt=%0d exp pc=0 cnt=7", pc, issue_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (issue_cnt !== 4'(m_cnt) || pc !== m_pc) begin
        errors++; $display("FAIL sat[%0d] got pc=%h cnt=%0d exp pc=%h cnt=%0d", i, pc, issue_cnt, m_pc, m_cnt);
      end
    end
    checks++; if (issue_cnt !== 4'd15) begin errors++; $display("FAIL saturate got %0d exp 15", issue_cnt); end
  endtask

  task automatic test_halt();
    jump_en = 1'b1; jump_tgt = 32'h40; pc_ready = 1'b0;
    tick();
    jump_en = 1'b0; halt = 1'b1; pc_ready = 1'b1;
    tick();
    halt = 1'b0; pc_ready = 1'b0;
    checks++; if (pc !== 32'h44 || pc_valid !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL halt_xfer got pc=%h v=%b r=%b exp pc=44 v=0 r=0", pc, pc_valid, running);
    end
    branch_en = 1'b1; branch_tgt = 32'h80;
    tick();
    branch_en = 1'b0;
    checks++; if (pc !== 32'h80 || pc_valid !== 1'b0) begin
      errors++; $display("FAIL halt_branch got pc=%h v=%b exp pc=80 v=0", pc, pc_valid);
    end
    tick();
    checks++; if (pc !== 32'h80 || pc_valid !== 1'b0) begin
      errors++; $display("FAIL halt_hold got pc=%h v=%b exp pc=80 v=0", pc, pc_valid);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pc !== 32'h80 || pc_valid !== 1'b1 || running !== 1'b1) begin
      errors++; $display("FAIL halt_restart got pc=%h v=%b r=%b exp pc=80 v=1 r=1", pc, pc_valid, running);
    end
    halt = 1'b1; start = 1'b1;
    tick();
    halt = 1'b0; start = 1'b0;
    checks++; if (pc_valid !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL halt_beats_start got v=%b r=%b exp 0/0", pc_valid, running);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      start      = ($urandom_range(0, 3) == 0);
      halt       = ($urandom_range(0, 9) == 0);
      jump_en    = ($urandom_range(0, 7) == 0);
      branch_en  = ($urandom_range(0, 5) == 0);
      jump_tgt   = $urandom;
      branch_tgt = $urandom;
      pc_ready   = $urandom_range(0, 1) == 1;
      tick();
      checks++; if (pc !== m_pc || pc_valid !== m_run || running !== m_run || issue_cnt !== 4'(m_cnt)) begin
        errors++;
        $display("FAIL rand[%0d] got pc=%h v=%b r=%b cnt=%0d exp pc=%h v=%b cnt=%0d",
                 c, pc, pc_valid, running, issue_cnt, m_pc, m_run, m_cnt);
      end
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0; pc_ready = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (pc !== 32'h0 || pc_valid !== 1'b0 || issue_cnt !== 4'd0 || running !== 1'b0) begin
      errors++; $display("FAIL async_reset got pc=%h v=%b cnt=%0d r=%b exp 0/0/0/0", pc, pc_valid, issue_cnt, running);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h0 || pc_valid !== 1'b0 || issue_cnt !== 4'd0) begin
        errors++; $display("FAIL post_reset_idle[%0d] got pc=%h v=%b cnt=%0d exp 0/0/0", i, pc, pc_valid, issue_cnt);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_start got pc=%h v=%b exp 0/1", pc, pc_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap_saturate();
    test_halt();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
